pipe_ctrl_unit: RTL and testbench
=================================

# pipe_ctrl_unit

Pipelined MIPS control unit: decodes the ID-stage opcode into control signals and carries them through EX, MEM and WB pipeline registers. It detects load-use hazards, inserts a configurable number of bubbles while raising `stall`, and converts the ID-stage instruction to a bubble on branch/jump flush. It sits between the IF/ID register and the datapath stage registers, replacing the purely combinational decoder.

## Interface
- `OPCODE_W`, 6: opcode width.
- `REG_ADDR_W`, 5: register address width.
- `STALL_CYCLES`, 1: bubbles inserted per load-use hazard, legal 1..3.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `id_valid`  in  1  ID stage holds a real instruction.
- `id_op_code`  in  OPCODE_W  instruction[31:26].
- `id_rs`, `id_rt`  in  REG_ADDR_W  source fields of the ID instruction.
- `ex_flush`  in  1  EX resolved a taken branch or jump; kill the ID instruction.
- `stall`  out  1  hold PC and IF/ID (combinational).
- `ex_valid`, `ex_reg_dst`, `ex_alu_src`, `ex_branch`, `ex_branch_ne`, `ex_jump`, `ex_illegal`  out  1 each  EX-stage controls.
- `ex_alu_op`  out  2  ALU op class: 00 add, 01 sub/compare, 10 R-type funct, 11 or-immediate.
- `ex_rt`  out  REG_ADDR_W  registered `id_rt`.
- `ex_mem_read`, `ex_mem_write`, `ex_mem_to_reg`, `ex_reg_write`  out  1 each.
- `mem_valid`, `mem_mem_read`, `mem_mem_write`, `mem_mem_to_reg`, `mem_reg_write`  out  1 each.
- `wb_valid`, `wb_mem_to_reg`, `wb_reg_write`  out  1 each.

## Operation
- Decode, with the team opcode map:
  - 0 R-type: reg_dst, reg_write, alu_op=10.
  - 1 addi: alu_src, reg_write, alu_op=00.
  - 2 j: jump.
  - 4 beq: branch, alu_op=01.
  - 5 bne: branch, branch_ne, alu_op=01.
  - 13 ori: alu_src, reg_write, alu_op=11.
  - 35 lw: alu_src, mem_to_reg, reg_write, mem_read.
  - 43 sw: alu_src, mem_write.
  - Any other opcode: all controls 0, `illegal`=1.
- Bubble: all control bits 0, `valid`=0, `illegal`=0, `ex_rt`=0.
- Uses-rt: opcodes 0, 4, 5 and 43. `id_rs` always counts as a source.
- Hazard `hz`: `ex_valid` & `ex_mem_read` & `ex_rt`≠0 & `id_valid` & (`ex_rt`==`id_rs` | (uses-rt & `ex_rt`==`id_rt`)).
- Stall counter `sc`, 2 bits, reset 0.
  - `stall` = `hz` | (`sc`≠0).
  - When `hz` & `sc`==0: `sc` ← STALL_CYCLES−1.
  - While `sc`≠0: decrement each cycle. `hz` is ignored while `sc`≠0.
- EX load each cycle:
  - `ex_flush` → bubble. Also sets `sc` ← 0.
  - Else `stall` → bubble.
  - Else `id_valid`=0 → bubble.
  - Else the decoded word with `ex_valid`=1.
- EX→MEM and MEM→WB copy the relevant fields every cycle, unconditionally. There is no stall or flush on these stages.
- `ex_illegal` is informational only; the illegal instruction still travels as a nop.

## Timing
- Reset (async assert, synchronous effect on deassert): every registered output 0, `sc`=0. `stall` then depends only on inputs (0 since `ex_valid`=0).
- Latency: ID decode visible on EX outputs 1 cycle after the edge, MEM after 2, WB after 3.
- `stall` is combinational from ID inputs and EX registers, with no registered delay. Upstream holds ID inputs stable while `stall`=1.
- Load-use with STALL_CYCLES=N:
  - `stall` high for exactly N cycles.
  - N bubbles enter EX.
  - The dependent instruction enters EX on the edge after `stall` falls.
- Flush during stall: flush wins. `stall` drops next cycle unless a new `hz` exists.
- Reset mid-stall aborts the stall immediately.
- Back-to-back loads each trigger an independent hazard check once `sc`==0.

## Configuration
- `CTRL_HAZARD_DETECT_EN`
  - Defined: load-use detection, `sc` and bubble insertion as above.
  - Undefined:
    - `hz` is tied 0, so `stall` is constant 0.
    - `sc` is removed.
    - STALL_CYCLES is ignored.
    - Software is responsible for nops after loads. All other behaviour is unchanged.

## Test plan
- Reset then `id_valid`=1, op=35 → next cycle `ex_mem_read`=`ex_mem_to_reg`=`ex_reg_write`=1; `wb_reg_write`=1 three cycles after the input.
- lw $t0(rt=8) then add with rs=8, STALL_CYCLES=1 → `stall`=1 for one cycle, one bubble (`ex_valid`=0), then add decoded into EX.
- STALL_CYCLES=3, lw rt=9, then sw rt=9 → `stall` high 3 cycles, 3 bubbles. Same sequence with lw rt=0 → no stall.
- bne (op=5) with `ex_flush`=1 asserted the same cycle → EX gets a bubble; with no flush → `ex_branch`=`ex_branch_ne`=1, `ex_alu_op`=01.
- Op=63 → `ex_illegal`=1, all other EX controls 0. Assert `rst_n`=0 during a 3-cycle stall → `stall`, `sc` and all outputs 0 immediately.
- Build without `CTRL_HAZARD_DETECT_EN` and repeat the load-use sequence → `stall` never 1; add enters EX directly after lw.

Source files
------------

// File: rtl/pipe_ctrl_unit_if.sv
// Bundle of the ID-stage inputs and EX/MEM/WB control outputs of pipe_ctrl_unit.
// The master side drives the ID instruction fields; the slave is the control unit.
interface pipe_ctrl_unit_if #(
  parameter int OPCODE_W   = 6,
  parameter int REG_ADDR_W = 5
);
  logic                  id_valid;
  logic [OPCODE_W-1:0]   id_op_code;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  ex_flush;
  logic                  stall;

  logic                  ex_valid, ex_reg_dst, ex_alu_src, ex_branch, ex_branch_ne;
  logic                  ex_jump, ex_illegal;
  logic [1:0]            ex_alu_op;
  logic [REG_ADDR_W-1:0] ex_rt;
  logic                  ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write;
  logic                  mem_valid, mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_reg_write;
  logic                  wb_valid, wb_mem_to_reg, wb_reg_write;

  modport master (
    output id_valid, id_op_code, id_rs, id_rt, ex_flush,
    input  stall,
    input  ex_valid, ex_reg_dst, ex_alu_src, ex_branch, ex_branch_ne, ex_jump, ex_illegal,
    input  ex_alu_op, ex_rt, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write,
    input  mem_valid, mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_reg_write,
    input  wb_valid, wb_mem_to_reg, wb_reg_write
  );

  modport slave (
    input  id_valid, id_op_code, id_rs, id_rt, ex_flush,
    output stall,
    output ex_valid, ex_reg_dst, ex_alu_src, ex_branch, ex_branch_ne, ex_jump, ex_illegal,
    output ex_alu_op, ex_rt, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write,
    output mem_valid, mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_reg_write,
    output wb_valid, wb_mem_to_reg, wb_reg_write
  );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// Pipelined MIPS control unit: ID decode, EX/MEM/WB control registers, load-use stall.
// Load-use detection and bubble insertion exist only when CTRL_HAZARD_DETECT_EN is defined.
module pipe_ctrl_unit #(
  parameter int OPCODE_W     = 6,
  parameter int REG_ADDR_W   = 5,
  parameter int STALL_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  pipe_ctrl_unit_if.slave   bus
);

  typedef struct packed {
    logic                  valid;
    logic                  reg_dst;
    logic                  alu_src;
    logic                  branch;
    logic                  branch_ne;
    logic                  jump;
    logic                  illegal;
    logic [1:0]            alu_op;
    logic [REG_ADDR_W-1:0] rt;
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_to_reg;
    logic                  reg_write;
  } ex_ctrl_t;

  typedef struct packed {
    logic valid;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic reg_write;
  } mem_ctrl_t;

  typedef struct packed {
    logic valid;
    logic mem_to_reg;
    logic reg_write;
  } wb_ctrl_t;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_ORI   = OPCODE_W'(13);
  localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(35);
  localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(43);

  if (STALL_CYCLES < 1 || STALL_CYCLES > 3) begin : g_bad_stall_cycles
    $error("pipe_ctrl_unit: STALL_CYCLES must be in 1..3");
  end

  ex_ctrl_t  dec;
  ex_ctrl_t  ex_d, ex_q;
  mem_ctrl_t mem_d, mem_q;
  wb_ctrl_t  wb_d, wb_q;
  logic      stall;

  always_comb begin
    dec       = '0;
    dec.valid = 1'b1;
    dec.rt    = bus.id_rt;
    case (bus.id_op_code)
      OP_RTYPE: begin dec.reg_dst = 1'b1; dec.reg_write = 1'b1; dec.alu_op = 2'b10; end
      OP_ADDI:  begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_op = 2'b00; end
      OP_J:     dec.jump = 1'b1;
      OP_BEQ:   begin dec.branch = 1'b1; dec.alu_op = 2'b01; end
      OP_BNE:   begin dec.branch = 1'b1; dec.branch_ne = 1'b1; dec.alu_op = 2'b01; end
      OP_ORI:   begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_op = 2'b11; end
      OP_LW: begin
        dec.alu_src    = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.reg_write  = 1'b1;
        dec.mem_read   = 1'b1;
      end
      OP_SW:    begin dec.alu_src = 1'b1; dec.mem_write = 1'b1; end
      default:  dec.illegal = 1'b1;
    endcase
  end

`ifdef CTRL_HAZARD_DETECT_EN
  localparam logic [1:0] SC_LOAD = 2'(STALL_CYCLES - 1);

  logic [1:0] sc_d, sc_q;
  logic       uses_rt;
  logic       hz;

  always_comb begin
    uses_rt = (bus.id_op_code == OP_RTYPE) || (bus.id_op_code == OP_BEQ) ||
              (bus.id_op_code == OP_BNE)   || (bus.id_op_code == OP_SW);
    hz = ex_q.valid && ex_q.mem_read && (ex_q.rt != '0) && bus.id_valid &&
         ((ex_q.rt == bus.id_rs) || (uses_rt && (ex_q.rt == bus.id_rt)));
    stall = hz || (sc_q != 2'd0);
    // A pending stall window masks new hazards; flush clears it outright.
    sc_d = sc_q;
    if (bus.ex_flush)        sc_d = 2'd0;
    else if (sc_q != 2'd0)   sc_d = sc_q - 2'd1;
    else if (hz)             sc_d = SC_LOAD;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sc_q <= 2'd0;
    else        sc_q <= sc_d;
  end
`else
  logic unused_id_rs;

  assign unused_id_rs = ^bus.id_rs;
  assign stall        = 1'b0;
`endif

  always_comb begin
    ex_d = dec;
    if (bus.ex_flush || stall || !bus.id_valid) ex_d = '0;

    mem_d.valid      = ex_q.valid;
    mem_d.mem_read   = ex_q.mem_read;
    mem_d.mem_write  = ex_q.mem_write;
    mem_d.mem_to_reg = ex_q.mem_to_reg;
    mem_d.reg_write  = ex_q.reg_write;

    wb_d.valid      = mem_q.valid;
    wb_d.mem_to_reg = mem_q.mem_to_reg;
    wb_d.reg_write  = mem_q.reg_write;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  assign bus.stall          = stall;
  assign bus.ex_valid       = ex_q.valid;
  assign bus.ex_reg_dst     = ex_q.reg_dst;
  assign bus.ex_alu_src     = ex_q.alu_src;
  assign bus.ex_branch      = ex_q.branch;
  assign bus.ex_branch_ne   = ex_q.branch_ne;
  assign bus.ex_jump        = ex_q.jump;
  assign bus.ex_illegal     = ex_q.illegal;
  assign bus.ex_alu_op      = ex_q.alu_op;
  assign bus.ex_rt          = ex_q.rt;
  assign bus.ex_mem_read    = ex_q.mem_read;
  assign bus.ex_mem_write   = ex_q.mem_write;
  assign bus.ex_mem_to_reg  = ex_q.mem_to_reg;
  assign bus.ex_reg_write   = ex_q.reg_write;
  assign bus.mem_valid      = mem_q.valid;
  assign bus.mem_mem_read   = mem_q.mem_read;
  assign bus.mem_mem_write  = mem_q.mem_write;
  assign bus.mem_mem_to_reg = mem_q.mem_to_reg;
  assign bus.mem_reg_write  = mem_q.reg_write;
  assign bus.wb_valid       = wb_q.valid;
  assign bus.wb_mem_to_reg  = wb_q.mem_to_reg;
  assign bus.wb_reg_write   = wb_q.reg_write;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench for pipe_ctrl_unit: a table-driven model predicts each EX word and the stall line,
// and a negedge monitor compares EX, MEM and WB against the queued predictions.
module tb_pipe_ctrl_unit;
  localparam int STALL_N = 3;

  typedef struct packed {
    logic       valid, reg_dst, alu_src, branch, branch_ne, jump, illegal;
    logic [1:0] alu_op;
    logic [4:0] rt;
    logic       mem_read, mem_write, mem_to_reg, reg_write;
  } ex_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_ctrl_unit_if #(.OPCODE_W(6), .REG_ADDR_W(5)) bus ();

  pipe_ctrl_unit #(.OPCODE_W(6), .REG_ADDR_W(5), .STALL_CYCLES(STALL_N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int  checks = 0;
  int  passes = 0;
  ex_t op_table [64];
  ex_t exq [$];
  ex_t cur_ex = '0;
  int  cyc = 0;
  int  stall_until = 0;
  bit  last_stall = 1'b0;
  bit  mon_en = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
  endtask

  function automatic ex_t mk(bit rd, bit asrc, bit br, bit bne, bit j, logic [1:0] aop,
                             bit mr, bit mw, bit m2r, bit rw);
    ex_t e = '0;
    e.reg_dst = rd;  e.alu_src = asrc; e.branch = br; e.branch_ne = bne; e.jump = j;
    e.alu_op = aop;  e.mem_read = mr;  e.mem_write = mw; e.mem_to_reg = m2r; e.reg_write = rw;
    return e;
  endfunction

  function automatic ex_t ref_decode(input bit [5:0] op, input bit [4:0] rt);
    ex_t e = op_table[op];
    e.valid = 1'b1;
    e.rt    = rt;
    return e;
  endfunction

  function automatic bit uses_rt(input bit [5:0] op);
    return (op == 6'd0) || (op == 6'd4) || (op == 6'd5) || (op == 6'd43);
  endfunction

  function automatic ex_t ex_act();
    return {bus.ex_valid, bus.ex_reg_dst, bus.ex_alu_src, bus.ex_branch, bus.ex_branch_ne,
            bus.ex_jump, bus.ex_illegal, bus.ex_alu_op, bus.ex_rt, bus.ex_mem_read,
            bus.ex_mem_write, bus.ex_mem_to_reg, bus.ex_reg_write};
  endfunction

  function automatic logic [4:0] mem_act();
    return {bus.mem_valid, bus.mem_mem_read, bus.mem_mem_write, bus.mem_mem_to_reg, bus.mem_reg_write};
  endfunction

  function automatic logic [2:0] wb_act();
    return {bus.wb_valid, bus.wb_mem_to_reg, bus.wb_reg_write};
  endfunction

  // Called #1 after a rising edge; returns #1 after the next rising edge.
  task automatic drive_cycle(input bit v, input bit [5:0] op, input bit [4:0] rs,
                             input bit [4:0] rt, input bit fl);
    bit  hz, st;
    ex_t nx;
    bus.id_valid = v; bus.id_op_code = op; bus.id_rs = rs; bus.id_rt = rt; bus.ex_flush = fl;
    #1;
    hz = cur_ex.valid && cur_ex.mem_read && (cur_ex.rt != 0) && v &&
         ((cur_ex.rt == rs) || (uses_rt(op) && (cur_ex.rt == rt)));
`ifdef CTRL_HAZARD_DETECT_EN
    begin
      bit win;
      win = (cyc < stall_until);
      st  = win || hz;
      if (fl) stall_until = 0;
      else if (!win && hz) stall_until = cyc + STALL_N;
    end
`else
    st = 1'b0;
    if (hz) st = 1'b0;
`endif
    check("stall", bus.stall, st);
    nx = (fl || st || !v) ? '0 : ref_decode(op, rt);
    last_stall = st;
    @(posedge clk);
    cyc++;
    exq.push_back(nx);
    cur_ex = nx;
    #1;
  endtask

  // Upstream behaviour: hold the instruction until it is accepted.
  task automatic issue(input bit v, input bit [5:0] op, input bit [4:0] rs,
                       input bit [4:0] rt, input bit fl);
    int n = 0;
    do begin
      drive_cycle(v, op, rs, rt, fl);
      n++;
    end while (last_stall && n < 8);
    if (last_stall) begin
      checks++;
      $display("FAIL issue_timeout actual=stalled required=accepted_within_8 at %0t", $time);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 6'd0, 5'd0, 5'd0, 1'b0);
  endtask

  initial begin : monitor
    ex_t e;
    ex_t h1 = '0;
    ex_t h2 = '0;
    forever begin
      @(negedge clk);
      if (mon_en && exq.size() > 0) begin
        e = exq.pop_front();
        check("ex_word", ex_act(), e);
        check("mem_word", mem_act(), {h1.valid, h1.mem_read, h1.mem_write, h1.mem_to_reg, h1.reg_write});
        check("wb_word", wb_act(), {h2.valid, h2.mem_to_reg, h2.reg_write});
        h2 = h1;
        h1 = e;
      end
    end
  end

  initial begin : stimulus
    bit [5:0] ops [9] = '{6'd0, 6'd1, 6'd2, 6'd4, 6'd5, 6'd13, 6'd35, 6'd35, 6'd43};
    bit       v, fl;
    bit [5:0] op;
    bit [4:0] rs, rt;

    for (int i = 0; i < 64; i++) begin
      op_table[i] = '0;
      op_table[i].illegal = 1'b1;
    end
    op_table[0]  = mk(1, 0, 0, 0, 0, 2'b10, 0, 0, 0, 1);
    op_table[1]  = mk(0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 1);
    op_table[2]  = mk(0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0);
    op_table[4]  = mk(0, 0, 1, 0, 0, 2'b01, 0, 0, 0, 0);
    op_table[5]  = mk(0, 0, 1, 1, 0, 2'b01, 0, 0, 0, 0);
    op_table[13] = mk(0, 1, 0, 0, 0, 2'b11, 0, 0, 0, 1);
    op_table[35] = mk(0, 1, 0, 0, 0, 2'b00, 1, 0, 1, 1);
    op_table[43] = mk(0, 1, 0, 0, 0, 2'b00, 0, 1, 0, 0);

    bus.id_valid = 1'b0; bus.id_op_code = '0; bus.id_rs = '0; bus.id_rt = '0; bus.ex_flush = 1'b0;
    #12;
    check("reset_ex", ex_act(), '0);
    check("reset_mem", mem_act(), '0);
    check("reset_wb", wb_act(), '0);
    check("reset_stall", bus.stall, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue(1, 6'd35, 5'd1, 5'd8, 0);
    issue(1, 6'd0, 5'd8, 5'd2, 0);
    idle(4);
    issue(1, 6'd35, 5'd2, 5'd9, 0);
    issue(1, 6'd43, 5'd3, 5'd9, 0);
    idle(4);
    issue(1, 6'd35, 5'd2, 5'd0, 0);
    issue(1, 6'd43, 5'd0, 5'd0, 0);
    idle(4);
    issue(1, 6'd5, 5'd1, 5'd2, 1);
    issue(1, 6'd5, 5'd1, 5'd2, 0);
    issue(1, 6'd63, 5'd4, 5'd6, 0);
    idle(4);
    // Flush arriving in the middle of a stall window.
    drive_cycle(1, 6'd35, 5'd1, 5'd7, 0);
    drive_cycle(1, 6'd0, 5'd7, 5'd1, 0);
    drive_cycle(1, 6'd0, 5'd7, 5'd1, 1);
    issue(1, 6'd0, 5'd7, 5'd1, 0);
    idle(4);

    for (int i = 0; i < 400; i++) begin
      v  = ($urandom_range(0, 99) < 85);
      op = ($urandom_range(0, 9) == 9) ? 6'($urandom_range(0, 63)) : ops[$urandom_range(0, 8)];
      rs = 5'($urandom_range(0, 3));
      rt = 5'($urandom_range(0, 3));
      fl = ($urandom_range(0, 99) < 8);
      issue(v, op, rs, rt, fl);
    end

    // Reset asserted while a stall window is open.
    drive_cycle(1, 6'd35, 5'd1, 5'd5, 0);
    drive_cycle(1, 6'd0, 5'd5, 5'd1, 0);
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    check("queue_drained", exq.size(), 0);
    rst_n = 1'b0;
    #1;
    check("midreset_stall", bus.stall, 1'b0);
    check("midreset_ex", ex_act(), '0);
    check("midreset_mem", mem_act(), '0);
    check("midreset_wb", wb_act(), '0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
